// File: rtl/dllp_pkg.sv
// Shared DLLP definitions: byte count, CRC-16 constants, transmitted-CRC function, queue entry type.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package dllp_pkg;

    localparam int          DLLP_BYTES = 6;
    localparam logic [15:0] CRC_POLY   = 16'h100B;
    localparam logic [15:0] CRC_SEED   = 16'hFFFF;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } asm_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        crc_err;
    } dllp_entry_t;

    // Returns {byte4, byte5} exactly as they appear on the wire. Bytes 0..3
    // are fed bit 0 first; the inverted remainder has each byte bit-reversed.
    function automatic logic [15:0] dllp_crc16(input logic [31:0] d);
        logic [15:0] c;
        logic [15:0] tx;
        logic        fb;
        c  = CRC_SEED;
        tx = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ d[24 - 8*i + j];
                c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
            end
        end
        c = ~c;
        for (int j = 0; j < 8; j++) begin
            tx[8 + j] = c[15 - j];
            tx[j]     = c[7 - j];
        end
        return tx;
    endfunction

endpackage

// File: rtl/dllp_rx_checker_if.sv
// Byte-lane input bus from the RX PHY plus the checked-DLLP valid/ready output stream.
// Latency: n/a (wiring only).
// Backpressure: dllp_ready from the consumer holds the head entry.
// Ports: pl_data/pl_valid/pl_dllpstart/pl_dllpend (per-byte lanes), dllp_valid/dllp_ready/dllp_data/dllp_crc_err.
interface dllp_rx_checker_if #(
    parameter int NBYTES = 8
);
    logic [8*NBYTES-1:0] pl_data;
    logic [NBYTES-1:0]   pl_valid;
    logic [NBYTES-1:0]   pl_dllpstart;
    logic [NBYTES-1:0]   pl_dllpend;
    logic                dllp_valid;
    logic                dllp_ready;
    logic [31:0]         dllp_data;
    logic                dllp_crc_err;

    // master: PHY side driving lanes plus the DLL engine consuming DLLPs
    modport master (
        output pl_data, pl_valid, pl_dllpstart, pl_dllpend, dllp_ready,
        input  dllp_valid, dllp_data, dllp_crc_err
    );

    modport slave (
        input  pl_data, pl_valid, pl_dllpstart, pl_dllpend, dllp_ready,
        output dllp_valid, dllp_data, dllp_crc_err
    );
endinterface

// File: rtl/dllp_rx_fifo.sv
// FWFT queue of checked DLLPs with two in-order write ports and one read port.
// Latency: write visible at head one edge after push; head is combinational from storage.
// Backpressure: caller limits push_num to free_cnt (plus same-cycle pop); pop ignored when empty.
// Ports: push_num/push_dat0/push_dat1 in, pop in, head_vld/head_dat/free_cnt out.
module dllp_rx_fifo
    import dllp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               push_num,
    input  dllp_entry_t              push_dat0,
    input  dllp_entry_t              push_dat1,
    input  logic                     pop,
    output logic                     head_vld,
    output dllp_entry_t              head_dat,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dllp_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop_ok;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign free_cnt = CW'(DEPTH) - count;
    assign pop_ok   = pop & head_vld;

    // When full, a pop and a push share the head slot: the head is read out
    // combinationally this cycle and overwritten at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_num != 2'd0) mem[wr_ptr] <= push_dat0;
            if (push_num == 2'd2) mem[wr_ptr + AW'(1)] <= push_dat1;
            wr_ptr <= wr_ptr + AW'(push_num);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(push_num) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/dllp_rx_checker.sv
// Reassembles 6-byte DLLPs from the PHY byte lanes, checks CRC/framing, queues them for the DLL.
// Latency: 1 cycle from the end byte to the queue head; framing_err registered 1 cycle after the bad byte.
// Backpressure: dllp_ready holds the head; completions that do not fit are dropped and overflow_err sticks.
// Ports: clk, reset (sync active-low), bus (slave: lanes in, DLLP stream out), framing_err, overflow_err, dllp_count.
module dllp_rx_checker
    import dllp_pkg::*;
#(
    parameter int NBYTES     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    dllp_rx_checker_if.slave         bus,
    output logic                     framing_err,
    output logic                     overflow_err,
    output logic [15:0]              dllp_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    asm_state_t                       st_q, st_d;
    logic [2:0]                       idx_q, idx_d;
    logic [DLLP_BYTES-2:0][7:0]       acc_q, acc_d;   // byte 5 is checked on arrival, never stored
    dllp_entry_t                      comp [2];
    logic [1:0]                       n_comp;
    logic                             ferr_d;

    logic [CW-1:0]                    free_cnt;
    logic [CW:0]                      room;
    logic [1:0]                       n_wr;
    logic                             drop;
    logic                             pop;
    logic                             head_vld;
    dllp_entry_t                      head_dat;

    // Unrolled per-lane assembler; each lane sees the state left by the lane before it.
    always_comb begin
        logic [7:0] byt;
        logic       s, e;
        st_d    = st_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ferr_d  = 1'b0;
        n_comp  = 2'd0;
        comp[0] = '0;
        comp[1] = '0;
        byt     = '0;
        s       = 1'b0;
        e       = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            byt = bus.pl_data[8*b +: 8];
            s   = bus.pl_dllpstart[b];
            e   = bus.pl_dllpend[b];
            if (bus.pl_valid[b]) begin
                if (s && e) begin
                    ferr_d = 1'b1;
                    st_d   = ST_IDLE;
                    idx_d  = 3'd0;
                end else if (s) begin
                    if (st_d == ST_COLLECT) ferr_d = 1'b1;
                    acc_d[0] = byt;
                    idx_d    = 3'd1;
                    st_d     = ST_COLLECT;
                end else if (st_d == ST_IDLE) begin
                    if (e) ferr_d = 1'b1;
                end else if (idx_d == 3'(DLLP_BYTES - 1)) begin
                    if (e) begin
                        comp[n_comp[0]].data    = {acc_d[0], acc_d[1], acc_d[2], acc_d[3]};
                        comp[n_comp[0]].crc_err =
                            (dllp_crc16({acc_d[0], acc_d[1], acc_d[2], acc_d[3]}) != {acc_d[4], byt});
                        n_comp = n_comp + 2'd1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    st_d  = ST_IDLE;
                    idx_d = 3'd0;
                end else if (e) begin
                    ferr_d = 1'b1;
                    st_d   = ST_IDLE;
                    idx_d  = 3'd0;
                end else begin
                    acc_d[idx_d] = byt;
                    idx_d        = idx_d + 3'd1;
                end
            end
        end
    end

    // A same-cycle pop frees a slot before the completions are counted.
    assign pop  = head_vld & bus.dllp_ready;
    assign room = {1'b0, free_cnt} + (CW+1)'(pop);
    assign drop = (room < (CW+1)'(n_comp));
    assign n_wr = drop ? room[1:0] : n_comp;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q         <= ST_IDLE;
            idx_q        <= 3'd0;
            acc_q        <= '0;
            framing_err  <= 1'b0;
            overflow_err <= 1'b0;
            dllp_count   <= 16'd0;
        end else begin
            st_q        <= st_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            framing_err <= ferr_d;
            if (drop) overflow_err <= 1'b1;
            dllp_count  <= dllp_count + 16'(n_wr);
        end
    end

    dllp_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_num  (n_wr),
        .push_dat0 (comp[0]),
        .push_dat1 (comp[1]),
        .pop       (pop),
        .head_vld  (head_vld),
        .head_dat  (head_dat),
        .free_cnt  (free_cnt)
    );

    // Head fields read as zero while empty so reset leaves every output at 0.
    assign bus.dllp_valid   = head_vld;
    assign bus.dllp_data    = head_vld ? head_dat.data : 32'd0;
    assign bus.dllp_crc_err = head_vld & head_dat.crc_err;
endmodule

// File: tb/tb_dllp_rx_checker.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized lane traffic.
// A queue-based reference model predicts every post-edge output; one process compares each cycle.
// Backpressure on dllp_ready is randomized, including long stalls to force overflow.
module tb_dllp_rx_checker;
    import dllp_pkg::*;

    localparam int NB    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [7:0] b;
        logic       s;
        logic       e;
    } sym_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        framing_err;
    logic        overflow_err;
    logic [15:0] dllp_count;

    int checks   = 0;
    int failures = 0;

    dllp_rx_checker_if #(.NBYTES(NB)) bus ();

    dllp_rx_checker #(
        .NBYTES     (NB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .framing_err  (framing_err),
        .overflow_err (overflow_err),
        .dllp_count   (dllp_count)
    );

    always #5 clk = ~clk;

    // lane stimulus for the coming edge
    logic [7:0]    ld [NB];
    logic [NB-1:0] lv, ls, le;
    logic          rdy = 1'b0;

    // reference model state
    bit          m_coll = 0;
    int          m_idx  = 0;
    logic [7:0]  m_acc [6];
    exp_t        exp_q [$];
    logic [15:0] exp_cnt  = 16'd0;
    logic        exp_ovf  = 1'b0;
    logic        exp_ferr = 1'b0;

    sym_t        sym_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // CRC by polynomial long division over the 48-bit frame (message then 16 zeros),
    // seed folded into the first 16 message bits.
    function automatic logic [15:0] ref_tx(input logic [31:0] d);
        logic [47:0] v;
        logic [15:0] r;
        logic [15:0] tx;
        v = '0;
        for (int k = 0; k < 32; k++) v[47 - k] = d[24 - 8*(k/8) + (k%8)];
        v[47:32] = v[47:32] ^ 16'hFFFF;
        for (int k = 47; k >= 16; k--)
            if (v[k]) v[k -: 17] = v[k -: 17] ^ 17'h1100B;
        r = ~v[15:0];
        for (int j = 0; j < 8; j++) begin
            tx[8 + j] = r[15 - j];
            tx[j]     = r[7 - j];
        end
        return tx;
    endfunction

    function automatic logic [47:0] mk(input logic [31:0] d);
        return {d, ref_tx(d)};
    endfunction

    task automatic clear_lanes();
        for (int b = 0; b < NB; b++) ld[b] = 8'($urandom);
        lv = '0;
        ls = '0;
        le = '0;
    endtask

    // place DLLP bytes first..last starting at lane0
    task automatic put_dllp(input logic [47:0] v, input int lane0, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            ld[lane0 + k - first] = v[47 - 8*k -: 8];
            lv[lane0 + k - first] = 1'b1;
            ls[lane0 + k - first] = (k == 0);
            le[lane0 + k - first] = (k == 5);
        end
    endtask

    task automatic model_edge();
        exp_t comps [$];
        exp_t ent;
        bit   ferr;
        ferr = 0;
        if (!reset) begin
            m_coll = 0;
            m_idx  = 0;
            exp_q.delete();
            exp_cnt  = 16'd0;
            exp_ovf  = 1'b0;
            exp_ferr = 1'b0;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            if (lv[b]) begin
                if (ls[b] && le[b]) begin
                    ferr = 1; m_coll = 0; m_idx = 0;
                end else if (ls[b]) begin
                    if (m_coll) ferr = 1;
                    m_acc[0] = ld[b]; m_idx = 1; m_coll = 1;
                end else if (!m_coll) begin
                    if (le[b]) ferr = 1;
                end else begin
                    m_acc[m_idx] = ld[b];
                    if (m_idx == 5) begin
                        if (le[b]) begin
                            ent.data = {m_acc[0], m_acc[1], m_acc[2], m_acc[3]};
                            ent.err  = ({m_acc[4], m_acc[5]} != ref_tx(ent.data));
                            comps.push_back(ent);
                        end else begin
                            ferr = 1;
                        end
                        m_coll = 0; m_idx = 0;
                    end else if (le[b]) begin
                        ferr = 1; m_coll = 0; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
        if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
        foreach (comps[i]) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(comps[i]);
                exp_cnt = exp_cnt + 16'd1;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        exp_ferr = ferr;
    endtask

    task automatic cycle();
        for (int b = 0; b < NB; b++) bus.pl_data[8*b +: 8] = ld[b];
        bus.pl_valid     = lv;
        bus.pl_dllpstart = ls;
        bus.pl_dllpend   = le;
        bus.dllp_ready   = rdy;
        model_edge();
        @(posedge clk);
        #3;
        clear_lanes();
    endtask

    task automatic drain();
        rdy = 1'b1;
        repeat (3) cycle();
        rdy = 1'b0;
    endtask

    task automatic refill();
        logic [47:0] v;
        int kind, n;
        kind = $urandom_range(0, 9);
        v = mk($urandom);
        if (kind <= 4 || kind == 5) begin
            if (kind == 5) v[$urandom_range(0, 47)] ^= 1'b1;
            for (int k = 0; k < 6; k++) sym_q.push_back('{v[47 - 8*k -: 8], k == 0, k == 5});
        end else if (kind == 6) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) sym_q.push_back('{8'($urandom), 1'b0, 1'b0});
        end else if (kind == 7) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k <= n; k++)
                sym_q.push_back('{v[47 - 8*k -: 8], k == 0, (k == n) && $urandom_range(0, 1) == 1});
        end else if (kind == 8) begin
            for (int k = 0; k < 6; k++) sym_q.push_back('{v[47 - 8*k -: 8], k == 0, 1'b0});
        end else begin
            sym_q.push_back('{8'($urandom), 1'b0, 1'b1});
        end
    endtask

    // per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("dllp_valid", bus.dllp_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("dllp_data", bus.dllp_data, exp_q[0].data);
                check("dllp_crc_err", bus.dllp_crc_err, exp_q[0].err);
            end
            check("framing_err", framing_err, exp_ferr);
            check("overflow_err", overflow_err, exp_ovf);
            check("dllp_count", dllp_count, exp_cnt);
        end
    end

    initial begin
        logic [47:0] v;
        sym_t        sy;
        clear_lanes();
        reset = 1'b0;
        cycle();
        cycle();
        check("rst_valid", bus.dllp_valid, 1'b0);
        check("rst_data", bus.dllp_data, 32'd0);
        check("rst_crc_err", bus.dllp_crc_err, 1'b0);
        check("rst_ferr", framing_err, 1'b0);
        check("rst_ovf", overflow_err, 1'b0);
        check("rst_count", dllp_count, 16'd0);
        reset = 1'b1;

        // single DLLP in lanes 1..6
        rdy = 1'b1;
        put_dllp(mk(32'h0011_2233), 1, 0, 5);
        cycle();
        check("t1_valid", bus.dllp_valid, 1'b1);
        check("t1_data", bus.dllp_data, 32'h0011_2233);
        check("t1_crc_err", bus.dllp_crc_err, 1'b0);
        check("t1_count", dllp_count, 16'd1);
        drain();

        // split across two cycles
        put_dllp(mk(32'hA000_012C), 5, 0, 2);
        cycle();
        check("t2_notyet", bus.dllp_valid, 1'b0);
        put_dllp(mk(32'hA000_012C), 0, 3, 5);
        cycle();
        check("t2_data", bus.dllp_data, 32'hA000_012C);
        check("t2_count", dllp_count, 16'd2);
        drain();

        // two completions in one cycle, ending at lanes 0 and 6
        put_dllp(mk(32'h4000_0055), 3, 0, 4);
        cycle();
        put_dllp(mk(32'h4000_0055), 0, 5, 5);
        put_dllp(mk(32'h8123_4567), 1, 0, 5);
        cycle();
        check("t3_count", dllp_count, 16'd4);
        check("t3_first", bus.dllp_data, 32'h4000_0055);
        rdy = 1'b1;
        cycle();
        check("t3_second", bus.dllp_data, 32'h8123_4567);
        drain();

        // single-bit corruption of byte 4
        v = mk(32'h1020_3040);
        v[15] = ~v[15];
        put_dllp(v, 0, 0, 5);
        cycle();
        check("t4_crc_err", bus.dllp_crc_err, 1'b1);
        check("t4_count", dllp_count, 16'd5);
        drain();

        // end flag at idx 3
        put_dllp(mk(32'h0102_0304), 0, 0, 2);
        ld[3] = 8'h5A; lv[3] = 1'b1; le[3] = 1'b1;
        cycle();
        check("t5_ferr", framing_err, 1'b1);
        check("t5_noentry", bus.dllp_valid, 1'b0);
        cycle();
        check("t5_ferr_pulse", framing_err, 1'b0);
        // start mid-DLLP restarts with a good DLLP
        put_dllp(mk(32'h0506_0708), 0, 0, 1);
        put_dllp(mk(32'hC0DE_0042), 2, 0, 5);
        cycle();
        check("t5b_ferr", framing_err, 1'b1);
        check("t5b_data", bus.dllp_data, 32'hC0DE_0042);
        check("t5b_crc_err", bus.dllp_crc_err, 1'b0);
        check("t5b_count", dllp_count, 16'd6);
        drain();

        // fill the queue, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            put_dllp(mk(32'h9000_0000 + i), 1, 0, 5);
            cycle();
        end
        check("t6_full_count", dllp_count, 16'd10);
        check("t6_no_ovf", overflow_err, 1'b0);
        put_dllp(mk(32'h9000_00FF), 1, 0, 5);
        cycle();
        check("t6_ovf", overflow_err, 1'b1);
        check("t6_count_held", dllp_count, 16'd10);
        check("t6_head", bus.dllp_data, 32'h9000_0000);
        reset = 1'b0;
        cycle();
        check("t6_rst_valid", bus.dllp_valid, 1'b0);
        check("t6_rst_ovf", overflow_err, 1'b0);
        check("t6_rst_count", dllp_count, 16'd0);
        check("t6_rst_data", bus.dllp_data, 32'd0);
        reset = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ((c % 400) < 150) rdy = ($urandom_range(0, 3) == 0);
            else                 rdy = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 399) != 0);
            for (int b = 0; b < NB; b++) begin
                if (sym_q.size() == 0) refill();
                if ($urandom_range(0, 4) != 0) begin
                    sy    = sym_q.pop_front();
                    ld[b] = sy.b;
                    lv[b] = 1'b1;
                    ls[b] = sy.s;
                    le[b] = sy.e;
                end else begin
                    lv[b] = 1'b0;
                    ls[b] = 1'($urandom_range(0, 1));
                    le[b] = 1'($urandom_range(0, 1));
                end
            end
            cycle();
        end
        reset = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dllp_rx_checker.md
# dllp_rx_checker

Data-link-layer receive front end that sits directly downstream of the RX physical-layer top. It consumes the LPIF-side byte stream (`pl_data` with the per-byte `pl_valid`, `pl_dllpstart` and `pl_dllpend` flags) and reassembles 6-byte DLLPs, which may span cycles. It checks each DLLP's CRC-16 and framing, and queues the checked DLLPs for the DLL receive engine (Ack/Nak and flow-control tracking) over a valid/ready handshake.

## Interface
Parameters:
- `NBYTES`, 8: byte lanes consumed per cycle, taken from the low bytes of the `pl_*` bus. Legal range is 6..11, which guarantees at most 2 DLLP completions per cycle.
- `FIFO_DEPTH`, 4: output queue entries; power of 2, minimum 2.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `pl_data`  in  8*NBYTES  byte b is `pl_data[8b+:8]`; byte 0 is first in time.
- `pl_valid`  in  NBYTES  byte b carries data.
- `pl_dllpstart`  in  NBYTES  byte b is the first DLLP byte (type byte).
- `pl_dllpend`  in  NBYTES  byte b is the last DLLP byte (CRC low byte).
- `dllp_valid`  out  1  queue head valid.
- `dllp_ready`  in  1  consumer accepts the head.
- `dllp_data`  out  32  DLLP bytes 0..3; byte 0 sits in [31:24].
- `dllp_crc_err`  out  1  head DLLP failed CRC. Delivered anyway so the DLL can count it.
- `framing_err`  out  1  one-cycle pulse on any framing violation.
- `overflow_err`  out  1  sticky; a completed DLLP was dropped because the queue was full.
- `dllp_count`  out  16  total DLLPs enqueued; wraps.

## Operation
- Bytes are processed in ascending b order, and only bytes with `pl_valid`=1 count. Bytes with `pl_valid`=0 are ignored entirely, including their start/end flags.
- Assembler state is IDLE or COLLECT, plus a byte index `idx` (0..5) and a 6-byte accumulator. State and index persist across cycles.
- IDLE, start byte: store it as byte 0, set `idx`=1, go to COLLECT.
- IDLE, non-start byte: discard silently. This byte is TLP or idle traffic.
- IDLE, end byte without start: `framing_err`.
- COLLECT, start byte: `framing_err`; abandon the partial DLLP and restart with this byte as byte 0.
- COLLECT, any other byte: store it at `idx` and increment `idx`.
- COLLECT, end byte with `idx`≠5: `framing_err`; discard and return to IDLE.
- COLLECT, byte at `idx`=5 without the end flag: `framing_err`; discard and return to IDLE.
- A DLLP is complete when the end byte lands at `idx`=5. It is then CRC-checked and returns to IDLE.
- A single byte carrying both start and end is a framing error.
- CRC rules:
  - CRC-16 over bytes 0..3: polynomial 100Bh, seed FFFFh, result inverted.
  - Transmitted order: byte 4 = CRC[15:8] and byte 5 = CRC[7:0], each bit-reversed per PCIe DLLP CRC mapping.
  - Mismatch sets `crc_err` for that entry.
- Enqueue:
  - Up to 2 completions per cycle are written in byte order.
  - If free entries are fewer than the completions, write what fits in order, drop the rest, and set `overflow_err`.
  - A same-cycle dequeue frees its slot before the writes are counted.
- `dllp_count` increments by the number actually enqueued.
- Queue is first-word fall-through; the head is popped when `dllp_valid`&`dllp_ready`.

## Timing
- Input-to-output latency is 1 cycle: a DLLP completing in cycle N is registered into the queue at edge N+1, and `dllp_valid` rises after that edge if the queue was empty.
- A DLLP split across cycles completes in the cycle carrying its end byte.
- `framing_err` is registered, asserted the cycle after the offending byte.
- Reset (`reset`=0 at a clock edge) returns all outputs to 0 and the state to IDLE with `idx`=0. It empties the queue and clears `overflow_err` and `dllp_count`.
- Reset mid-DLLP discards the partial DLLP with no error flagged.
- `dllp_data` and `dllp_crc_err` are stable while `dllp_valid`=1 and `dllp_ready`=0.

## Structure
- Shared package `dllp_pkg` holds:
  - `DLLP_BYTES`=6.
  - CRC polynomial and seed constants.
  - Function `dllp_crc16(input [31:0])` returning the transmitted 16-bit value.
  - Queue entry typedef: data[31:0] plus crc_err.
- Sub-module: `dllp_rx_fifo`, a synchronous FWFT queue with 2 write ports and 1 read port, plus a free-count output.
- The assembler is an unrolled per-byte loop in the top module.

## Test plan
1. A DLLP with correct CRC in bytes 1..6 of one cycle, `dllp_ready`=1 → one entry after 1 cycle, `dllp_crc_err`=0, `dllp_count`=1.
2. DLLP bytes 0..2 at bytes 5..7 of cycle N and bytes 3..5 at bytes 0..2 of N+1 → one entry after N+2, with data correctly ordered.
3. Two back-to-back DLLPs ending at bytes 0 and 6 in one cycle, `dllp_ready`=0 → 2 queue entries, `dllp_count`+=2; then drained in order.
4. Byte 4 of a DLLP corrupted by a single bit → entry delivered with `dllp_crc_err`=1.
5. End flag at `idx`=3; separately, a start flag mid-DLLP → `framing_err` pulse in each case; the restart in the second case yields a good DLLP.
6. `FIFO_DEPTH`=4 full with `dllp_ready`=0, then another DLLP → `overflow_err`=1 and `dllp_count` unchanged; reset then clears all outputs to 0.
